j17_control: RTL and testbench

Multi-cycle control unit for the J17 processor. It fetches 32-bit instructions over a request/valid handshake, decodes them, and drives the datapath control lines for one instruction at a time (alucode, operand selects, register/RAM enables, PC control). It sits between instruction memory and the datapath and guarantees exactly one PC update per retired instruction.

---
 rtl/j17_pkg.sv | 45 ++++
 rtl/j17_decode.sv | 57 +++++
 rtl/j17_control.sv | 140 ++++++++++++++
 tb/tb_j17_control.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j17_pkg.sv
// rtl/j17_pkg.sv - J17 control package: FSM states, opcode map, field positions, RAM encodings.
package j17_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_ALU_LAST  = 5'h0B;
    localparam logic [4:0] OP_MOVI      = 5'h0C;
    localparam logic [4:0] OP_LOAD      = 5'h0D;
    localparam logic [4:0] OP_STORE     = 5'h0E;
    localparam logic [4:0] OP_HALT      = 5'h0F;
    localparam logic [4:0] OP_BR_BASE   = 5'h10;
    localparam logic [4:0] OP_ALUI_BASE = 5'h18;
    localparam logic [4:0] OP_ILLEGAL   = 5'h1F;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int OP1_MSB = 26;
    localparam int OP1_LSB = 22;
    localparam int OP2_MSB = 21;
    localparam int OP2_LSB = 0;

    localparam logic [1:0] RAM_NONE  = 2'd0;
    localparam logic [1:0] RAM_READ  = 2'd1;
    localparam logic [1:0] RAM_WRITE = 2'd2;

    // Control fields captured with the instruction and held until WB.
    typedef struct packed {
        logic [4:0] alucode;
        logic       im_control;
        logic       flag1;
        logic [1:0] writecode;
        logic [2:0] pc_control;
        logic [1:0] ramenable;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/j17_decode.sv
// rtl/j17_decode.sv - Combinational opcode to control-field decode for the J17 control unit.
module j17_decode
    import j17_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [4:0] alucode,
    output logic       im_control,
    output logic       flag1,
    output logic [1:0] writecode,
    output logic [2:0] pc_control,
    output logic [1:0] ramenable,
    output logic       reg_write,
    output logic       stop,
    output logic       bad
);

    always_comb begin
        alucode    = '0;
        im_control = 1'b0;
        flag1      = 1'b0;
        writecode  = '0;
        pc_control = '0;
        ramenable  = RAM_NONE;
        reg_write  = 1'b0;
        stop       = 1'b0;
        bad        = 1'b0;
        if (opcode <= OP_ALU_LAST) begin
            alucode   = opcode;
            reg_write = 1'b1;
        end else if (opcode == OP_MOVI) begin
            im_control = 1'b1;
            writecode  = 2'd1;
            reg_write  = 1'b1;
        end else if (opcode == OP_LOAD) begin
            ramenable  = RAM_READ;
            im_control = 1'b1;
            flag1      = 1'b1;
            writecode  = 2'd1;
            reg_write  = 1'b1;
        end else if (opcode == OP_STORE) begin
            ramenable = RAM_WRITE;
        end else if (opcode == OP_HALT) begin
            stop = 1'b1;
        end else if (opcode == OP_ILLEGAL) begin
            stop = 1'b1;
            bad  = 1'b1;
        end else if (opcode < OP_ALUI_BASE) begin
            pc_control = opcode[2:0];
        end else begin
            // ALU immediate: operation selected by the low opcode bits
            alucode    = {2'b00, opcode[2:0]};
            im_control = 1'b1;
            reg_write  = 1'b1;
        end
    end

endmodule

// File: rtl/j17_control.sv
// rtl/j17_control.sv - J17 multi-cycle control FSM; J17_PERF_CNT_EN adds cycle/retired counters.
module j17_control
    import j17_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    input  logic        mem_ready,
    output logic [4:0]  alucode,
    output logic [4:0]  op1,
    output logic [21:0] op2,
    output logic        imControl,
    output logic        regenable,
    output logic        flag1,
    output logic [1:0]  ramenable,
    output logic [2:0]  pcControl,
    output logic [1:0]  writecode,
    output logic        pc_en,
    output logic        halted,
    output logic        illegal
`ifdef J17_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    state_t      state, next_state;
    ctrl_t       ctrl_q, dec_ctrl;
    logic [4:0]  op1_q;
    logic [21:0] op2_q;
    logic        stop_q, bad_q, illegal_q;

    logic [4:0] d_alucode;
    logic       d_im, d_flag1, d_reg_write, d_stop, d_bad;
    logic [1:0] d_writecode, d_ramenable;
    logic [2:0] d_pc_control;

    j17_decode u_decode (
        .opcode     (instr_data[OPC_MSB:OPC_LSB]),
        .alucode    (d_alucode),
        .im_control (d_im),
        .flag1      (d_flag1),
        .writecode  (d_writecode),
        .pc_control (d_pc_control),
        .ramenable  (d_ramenable),
        .reg_write  (d_reg_write),
        .stop       (d_stop),
        .bad        (d_bad)
    );

    assign dec_ctrl = {d_alucode, d_im, d_flag1, d_writecode, d_pc_control, d_ramenable, d_reg_write};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ctrl_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            stop_q    <= 1'b0;
            bad_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            // Capturing on the fetch handshake makes the fields visible from DECODE onward.
            if (state == S_FETCH && instr_valid) begin
                ctrl_q <= dec_ctrl;
                op1_q  <= instr_data[OP1_MSB:OP1_LSB];
                op2_q  <= instr_data[OP2_MSB:OP2_LSB];
                stop_q <= d_stop;
                bad_q  <= d_bad;
            end
            if (state == S_DECODE && bad_q) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        imem_addr  = '0;
        instr_req  = 1'b0;
        alucode    = '0;
        op1        = '0;
        op2        = '0;
        imControl  = 1'b0;
        flag1      = 1'b0;
        writecode  = '0;
        pcControl  = '0;
        ramenable  = RAM_NONE;
        regenable  = 1'b0;
        pc_en      = 1'b0;
        case (state)
            S_IDLE:   if (run) next_state = S_FETCH;
            S_FETCH:  if (instr_valid) next_state = S_DECODE;
            S_DECODE: next_state = stop_q ? S_HALT : S_EXEC;
            S_EXEC:   next_state = (ctrl_q.ramenable != RAM_NONE) ? S_MEM : S_WB;
            S_MEM:    if (mem_ready) next_state = S_WB;
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_HALT;
        endcase
        if (state == S_FETCH) begin
            instr_req = 1'b1;
            imem_addr = pc;
        end
        if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
            alucode   = ctrl_q.alucode;
            op1       = op1_q;
            op2       = op2_q;
            imControl = ctrl_q.im_control;
            flag1     = ctrl_q.flag1;
            writecode = ctrl_q.writecode;
            pcControl = ctrl_q.pc_control;
        end
        if (state == S_MEM) ramenable = ctrl_q.ramenable;
        if (state == S_WB) begin
            regenable = ctrl_q.reg_write;
            pc_en     = 1'b1;
        end
    end

    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;

`ifdef J17_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_en) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_j17_control.sv
// tb/tb_j17_control.sv - Directed self-checking bench for j17_control.
module tb_j17_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] pc = 32'h0000_0100;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        instr_req, imControl, regenable, flag1, pc_en, halted, illegal;
    logic [4:0]  alucode, op1;
    logic [21:0] op2;
    logic [1:0]  ramenable, writecode;
    logic [2:0]  pcControl;
`ifdef J17_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wire [77:0] all_out = {imem_addr, instr_req, alucode, op1, op2, imControl, regenable,
                           flag1, ramenable, pcControl, writecode, pc_en, halted, illegal};

    j17_control dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .pc          (pc),
        .imem_addr   (imem_addr),
        .instr_req   (instr_req),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .mem_ready   (mem_ready),
        .alucode     (alucode),
        .op1         (op1),
        .op2         (op2),
        .imControl   (imControl),
        .regenable   (regenable),
        .flag1       (flag1),
        .ramenable   (ramenable),
        .pcControl   (pcControl),
        .writecode   (writecode),
        .pc_en       (pc_en),
        .halted      (halted),
        .illegal     (illegal)
`ifdef J17_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic do_reset;
        reset = 1'b1;
        run = 1'b0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (all_out !== 78'd0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", all_out);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu;
        logic w;
        logic [13:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h01, 5'd3, 22'h0ABC};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            w = (c >= 2 && c <= 4);
            obs = {instr_req, pc_en, regenable, alucode, op1, imControl};
            exp = {(c == 1 || c == 5), (c == 4), (c == 4), (w ? 5'd1 : 5'd0), (w ? 5'd3 : 5'd0), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL alu c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1);
        end
    endtask

    task automatic test_load;
        logic w;
        logic [8:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h0D, 5'd7, 22'd5};
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            w = (c >= 2 && c <= 8);
            obs = {instr_req, pc_en, regenable, ramenable, imControl, flag1, writecode};
            exp = {(c == 1 || c == 9), (c == 8), (c == 8), ((c >= 4 && c <= 7) ? 2'd1 : 2'd0),
                   w, w, (w ? 2'd1 : 2'd0)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1);
            mem_ready = (c >= 7);
        end
    endtask

    task automatic test_branch;
        logic [9:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h13, 5'd0, 22'd0};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            obs = {pcControl, regenable, pc_en, alucode};
            exp = {((c >= 2 && c <= 4) ? 3'd3 : 3'd0), 1'b0, (c == 4), 5'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1);
        end
    endtask

    task automatic test_alui;
        logic w;
        logic [12:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h1A, 5'd9, 22'd17};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            w = (c >= 2 && c <= 4);
            obs = {alucode, imControl, flag1, writecode, regenable, pcControl};
            exp = {(w ? 5'd2 : 5'd0), w, 1'b0, 2'd0, (c == 4), 3'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL alui c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h1F, 5'd1, 22'd2};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            obs = {instr_req, pc_en, halted, illegal, regenable};
            exp = {(c == 1), 1'b0, (c >= 3), (c >= 3), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL illegal c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1 || c == 5);
        end
    endtask

    task automatic test_halt;
        logic [2:0] obs, exp;
        do_reset();
        run = 1'b1;
        instr_data = {5'h0F, 5'd0, 22'd0};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            obs = {pc_en, halted, illegal};
            exp = {1'b0, (c >= 3), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL halt c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 1);
        end
    endtask

    task automatic test_fetch_wait;
        logic [32:0] obs, exp;
        do_reset();
        run = 1'b1;
        pc = 32'h1234_5678;
        instr_data = {5'h02, 5'd4, 22'd0};
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            obs = {instr_req, imem_addr};
            exp = (c <= 6) ? {1'b1, 32'h1234_5678} : 33'd0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fetch_wait c=%0d got %h want %h", c, obs, exp);
            end
            instr_valid = (c == 6);
        end
        pc = 32'h0000_0100;
    endtask

    task automatic test_reset_mid_mem;
        do_reset();
        run = 1'b1;
        instr_data = {5'h0D, 5'd2, 22'd3};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            instr_valid = (c == 1);
        end
        checks++;
        if (ramenable !== 2'd1) begin
            errors++;
            $display("FAIL mem_before_reset ramenable got %0d want 1", ramenable);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 78'd0) begin
            errors++;
            $display("FAIL reset_mid_mem got %h want 0", all_out);
        end
        @(negedge clock);
        reset = 1'b0;
        run = 1'b1;
        instr_valid = 1'b0;
        instr_data = {5'h03, 5'd1, 22'd1};
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            checks++;
            if ({instr_req, pc_en} !== {(c == 1), (c == 4)}) begin
                errors++;
                $display("FAIL restart c=%0d got %b%b want %b%b", c, instr_req, pc_en, (c == 1), (c == 4));
            end
            instr_valid = (c == 1);
        end
    endtask

`ifdef J17_PERF_CNT_EN
    task automatic test_perf;
        do_reset();
        run = 1'b1;
        instr_valid = 1'b1;
        instr_data = {5'h05, 5'd1, 22'd2};
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            checks++;
            if ((pc_en & instr_req) !== 1'b0) begin
                errors++;
                $display("FAIL perf_overlap c=%0d got pc_en=%b instr_req=%b want not both", c, pc_en, instr_req);
            end
        end
        checks++;
        if ({cycle_cnt, retired_cnt} !== {32'd12, 32'd3}) begin
            errors++;
            $display("FAIL perf_cnt got cycle=%0d retired=%0d want 12 3", cycle_cnt, retired_cnt);
        end
        instr_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_alui();
        test_illegal();
        test_halt();
        test_fetch_wait();
        test_reset_mid_mem();
`ifdef J17_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
